// File: rtl/ahb_arbiter_if.sv
// AHB arbiter bus bundle: request/lock inputs, owner transfer info, grant outputs.
// The master modport is the bus side (requesters, owner transfer, hready);
// the slave modport is the arbiter itself.
// arb_state is a debug view of the arbiter FSM: 0=PARK 1=OWN 2=BURST 3=LOCK.
// Handshake: the arbiter acts only on hclk edges with hready=1; with hready=0
// every arbiter output holds, and an address phase completes only when hready=1.
interface ahb_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int MW          = 2
);
  logic [NUM_MASTERS-1:0] hbusreq;
  logic [NUM_MASTERS-1:0] hlock;
  logic [1:0]             htrans;
  logic [2:0]             hburst;
  logic                   hready;
  logic [NUM_MASTERS-1:0] hgrant;
  logic [MW-1:0]          hmaster;
  logic                   hmastlock;
  logic                   arb_busy;
  logic [1:0]             arb_state;

  modport master (
    output hbusreq, hlock, htrans, hburst, hready,
    input  hgrant, hmaster, hmastlock, arb_busy, arb_state
  );

  modport slave (
    input  hbusreq, hlock, htrans, hburst, hready,
    output hgrant, hmaster, hmastlock, arb_busy, arb_state
  );
endinterface

// File: rtl/ahb_arbiter.sv
// Multi-master AHB arbiter. Round-robin grant with burst and lock protection,
// parking on DEFAULT_MASTER when nobody requests. hmaster follows hgrant on the
// next hready edge (address-phase handover).
// Optional macro ARB_FIXED_PRIORITY_EN: lowest requesting index wins instead of
// round-robin; burst and lock protection are unchanged.
// hresetn is an asynchronous, active-high reset.
module ahb_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int MW             = 2
) (
  input  logic         hclk,
  input  logic         hresetn,
  ahb_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_PARK  = 2'd0,
    ST_OWN   = 2'd1,
    ST_BURST = 2'd2,
    ST_LOCK  = 2'd3
  } state_e;

  localparam logic [1:0]             TR_IDLE   = 2'b00;
  localparam logic [1:0]             TR_NONSEQ = 2'b10;
  localparam logic [1:0]             TR_SEQ    = 2'b11;
  localparam logic [MW-1:0]          DEF_IDX   = MW'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] ONE_HOT0  = NUM_MASTERS'(1);

  state_e                 state_q, state_d;
  logic [MW-1:0]          grant_q, grant_d;
  logic [MW-1:0]          ptr_q, ptr_d;
  logic [MW-1:0]          hmaster_q, hmaster_d;
  logic                   hmastlock_q, hmastlock_d;
  logic [3:0]             cnt_q, cnt_d;

  logic [MW-1:0]          winner;
  logic                   found;
  int                     sel_idx;
  logic [NUM_MASTERS-1:0] req_rot;
  logic [NUM_MASTERS-1:0] lock_sh;
  logic [NUM_MASTERS-1:0] req_sh;
  logic                   own_lock;
  logic                   own_req;
  logic                   any_req;
  logic                   is_nonseq;
  logic                   is_seq;
  logic                   fixed_burst;
  logic [3:0]             burst_last;
  logic                   rearb;

  // Decode transfer type, burst length and the owner's request/lock bits.
  always_comb begin
    is_nonseq   = bus.htrans == TR_NONSEQ;
    is_seq      = bus.htrans == TR_SEQ;
    fixed_burst = bus.hburst[2] | bus.hburst[1];
    lock_sh     = bus.hlock >> grant_q;
    req_sh      = bus.hbusreq >> grant_q;
    own_lock    = lock_sh[0];
    own_req     = req_sh[0];
    any_req     = |bus.hbusreq;
    unique case (bus.hburst)
      3'b010, 3'b011: burst_last = 4'd3;
      3'b100, 3'b101: burst_last = 4'd7;
      3'b110, 3'b111: burst_last = 4'd15;
      default:        burst_last = 4'd0;
    endcase
  end

  // Pick the next owner among the requesting masters.
  always_comb begin
    winner  = DEF_IDX;
    found   = 1'b0;
    sel_idx = 0;
    req_rot = '0;
`ifdef ARB_FIXED_PRIORITY_EN
    for (int k = 0; k < NUM_MASTERS; k++) begin
      sel_idx = k;
      req_rot = bus.hbusreq >> sel_idx;
      if (!found && req_rot[0]) begin
        winner = MW'(sel_idx);
        found  = 1'b1;
      end
    end
`else
    // Search starts just above the last winner; the last winner itself is
    // visited last, so it keeps the bus only when nobody else asks.
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      sel_idx = (int'(ptr_q) + k) % NUM_MASTERS;
      req_rot = bus.hbusreq >> sel_idx;
      if (!found && req_rot[0]) begin
        winner = MW'(sel_idx);
        found  = 1'b1;
      end
    end
`endif
  end

  // Next-state logic: beat counter, FSM, grant and address-phase owner.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    hmaster_d   = hmaster_q;
    hmastlock_d = hmastlock_q;
    rearb       = 1'b0;

    if (bus.hready) begin
      // Address phase hands over to whoever held the grant before this edge.
      hmaster_d   = grant_q;
      hmastlock_d = own_lock;

      if (is_nonseq) begin
        cnt_d = burst_last;
      end else if (is_seq) begin
        cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
      end

      unique case (state_q)
        ST_PARK: rearb = 1'b1;
        ST_OWN: begin
          if (own_lock && own_req) begin
            state_d = ST_LOCK;
          end else if (is_nonseq && fixed_burst) begin
            state_d = ST_BURST;
          end else begin
            rearb = 1'b1;
          end
        end
        ST_BURST: begin
          // A fresh fixed-length NONSEQ restarts the burst. The last beat
          // (counter at 1) or an already-finished count opens arbitration,
          // where a lock request beats the burst end.
          if (is_nonseq && fixed_burst) begin
            state_d = ST_BURST;
          end else if ((is_seq && cnt_q == 4'd1) || cnt_q == 4'd0) begin
            if (own_lock && own_req) begin
              state_d = ST_LOCK;
            end else begin
              rearb = 1'b1;
            end
          end
        end
        ST_LOCK: begin
          if (bus.htrans == TR_IDLE && !own_lock) begin
            rearb = 1'b1;
          end
        end
        default: state_d = ST_PARK;
      endcase

      if (rearb) begin
        if (any_req) begin
          grant_d = winner;
          ptr_d   = winner;
          state_d = ST_OWN;
        end else begin
          grant_d = DEF_IDX;
          state_d = ST_PARK;
        end
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge hclk or posedge hresetn) begin
    if (hresetn) begin
      state_q     <= ST_PARK;
      grant_q     <= DEF_IDX;
      ptr_q       <= DEF_IDX;
      cnt_q       <= 4'd0;
      hmaster_q   <= DEF_IDX;
      hmastlock_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      hmaster_q   <= hmaster_d;
      hmastlock_q <= hmastlock_d;
    end
  end

  // Outputs decode directly from registers, so reset shows at once.
  always_comb begin
    bus.hgrant    = ONE_HOT0 << grant_q;
    bus.hmaster   = hmaster_q;
    bus.hmastlock = hmastlock_q;
    bus.arb_busy  = (state_q == ST_BURST) || (state_q == ST_LOCK);
    bus.arb_state = state_q;
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Testbench for ahb_arbiter: directed scenarios plus random traffic, checked by
// a scoreboard fed from a behavioural reference model.
module tb_ahb_arbiter;

  localparam int NM  = 4;
  localparam int DEF = 0;
  localparam int W   = 10; // {hgrant[3:0], hmaster[1:0], hmastlock, arb_busy, state[1:0]}

  localparam int M_PARK  = 0;
  localparam int M_OWN   = 1;
  localparam int M_BURST = 2;
  localparam int M_LOCK  = 3;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  localparam logic [2:0] B_SINGLE = 3'b000;
  localparam logic [2:0] B_INCR4  = 3'b011;
  localparam logic [2:0] B_INCR8  = 3'b101;

  logic hclk;
  logic hresetn;

  ahb_arbiter_if #(.NUM_MASTERS(NM), .MW(2)) bus ();

  ahb_arbiter #(
    .NUM_MASTERS(NM),
    .DEFAULT_MASTER(DEF),
    .MW(2)
  ) dut (
    .hclk(hclk),
    .hresetn(hresetn),
    .bus(bus)
  );

  // ---------------- clock ----------------
  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_vec  = 0;
  int n_miss = 0;

  // ---------------- reference model ----------------
  int m_owner;      // granted master
  int m_ptr;        // last round-robin winner
  int m_hm;         // address-phase owner
  bit m_hml;        // locked address phase
  int m_left;       // beats of the current burst still to come after the last counted one
  int m_mode;       // PARK / OWN / BURST / LOCK

  function automatic int burst_beats(input logic [2:0] b);
    case (b)
      3'b000:         return 1;
      3'b001:         return 0;   // INCR: open-ended
      3'b010, 3'b011: return 4;
      3'b100, 3'b101: return 8;
      default:        return 16;
    endcase
  endfunction

  function automatic int pick_owner(input logic [NM-1:0] req, input int ptr);
`ifdef ARB_FIXED_PRIORITY_EN
    for (int i = 0; i < NM; i++) if (req[i]) return i;
`else
    for (int k = 1; k <= NM; k++) if (req[(ptr + k) % NM]) return (ptr + k) % NM;
`endif
    return DEF;
  endfunction

  task automatic model_reset();
    m_owner = DEF; m_ptr = DEF; m_hm = DEF; m_hml = 1'b0; m_left = 0; m_mode = M_PARK;
  endtask

  // Advance the model across one clock edge using the inputs now on the bus.
  task automatic model_edge();
    logic [NM-1:0] req;
    logic [NM-1:0] lck;
    int  beats;
    int  prev_left;
    bit  start_fixed;
    bit  last_beat;
    bit  lock_req;
    bit  rearb;
    req = bus.hbusreq;
    lck = bus.hlock;
    if (!bus.hready) return;
    beats       = burst_beats(bus.hburst);
    prev_left   = m_left;
    start_fixed = (bus.htrans == NONSEQ) && (beats > 1);
    lock_req    = lck[m_owner] && req[m_owner];
    rearb       = 1'b0;
    m_hm  = m_owner;
    m_hml = lck[m_owner];
    if (bus.htrans == NONSEQ) m_left = (beats > 1) ? beats - 1 : 0;
    else if (bus.htrans == SEQ && m_left > 0) m_left = m_left - 1;
    last_beat = (bus.htrans == SEQ && prev_left == 1) || prev_left == 0;
    case (m_mode)
      M_PARK:  rearb = 1'b1;
      M_OWN: begin
        if (lock_req) m_mode = M_LOCK;
        else if (start_fixed) m_mode = M_BURST;
        else rearb = 1'b1;
      end
      M_BURST: begin
        if (!start_fixed && last_beat) begin
          if (lock_req) m_mode = M_LOCK;
          else rearb = 1'b1;
        end
      end
      default: begin
        if (bus.htrans == IDLE && !lck[m_owner]) rearb = 1'b1;
      end
    endcase
    if (rearb) begin
      if (req == '0) begin
        m_owner = DEF; m_mode = M_PARK;
      end else begin
        m_owner = pick_owner(req, m_ptr); m_ptr = m_owner; m_mode = M_OWN;
      end
    end
  endtask

  function automatic logic [W-1:0] model_vec();
    logic [3:0] g;
    logic [1:0] hm;
    logic [1:0] st;
    logic       busy;
    g    = 4'b0001 << m_owner;
    hm   = 2'(m_hm);
    st   = 2'(m_mode);
    busy = (m_mode == M_BURST) || (m_mode == M_LOCK);
    return {g, hm, m_hml, busy, st};
  endfunction

  function automatic logic [W-1:0] dut_vec();
    return {bus.hgrant, bus.hmaster, bus.hmastlock, bus.arb_busy, bus.arb_state};
  endfunction

  task automatic check_vec(input string name, input logic [W-1:0] exp);
    logic [W-1:0] act;
    act = dut_vec();
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s @%0t {hgrant,hmaster,hmastlock,arb_busy,state}: got %b_%b_%b_%b_%b want %b_%b_%b_%b_%b",
               name, $time, act[9:6], act[5:4], act[3], act[2], act[1:0],
               exp[9:6], exp[5:4], exp[3], exp[2], exp[1:0]);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic reset_cycle();
    @(negedge hclk);
    hresetn = 1'b1;
    model_reset();
    exp_q.push_back(model_vec());
  endtask

  task automatic drive_cycle(input logic [3:0] req, input logic [3:0] lck,
                             input logic [1:0] tr, input logic [2:0] bu, input logic rdy);
    @(negedge hclk);
    hresetn     = 1'b0;
    bus.hbusreq = req;
    bus.hlock   = lck;
    bus.htrans  = tr;
    bus.hburst  = bu;
    bus.hready  = rdy;
    model_edge();
    exp_q.push_back(model_vec());
  endtask

  // Reset raised between clock edges; outputs must clear without an edge.
  task automatic reset_mid(input string name);
    @(negedge hclk);
    hresetn = 1'b1;
    #1;
    model_reset();
    check_vec(name, model_vec());
    exp_q.push_back(model_vec());
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [W-1:0] exp;
    forever begin
      @(posedge hclk);
      #1;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        check_vec("edge", exp);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not end, got running want finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    logic [3:0] rq;
    logic [3:0] lk;
    bus.hbusreq = '0;
    bus.hlock   = '0;
    bus.htrans  = IDLE;
    bus.hburst  = B_SINGLE;
    bus.hready  = 1'b1;
    hresetn     = 1'b1;
    model_reset();

    repeat (3) reset_cycle();
    // Parked with no requests.
    repeat (5) drive_cycle(4'b0000, 4'b0000, IDLE, B_SINGLE, 1'b1);

    // Two requesters doing singles.
    repeat (8) drive_cycle(4'b0110, 4'b0000, NONSEQ, B_SINGLE, 1'b1);

    // Hand the bus to master 2, then INCR4 while master 3 waits.
    for (int i = 0; i < 8 && !(m_owner == 2 && m_mode == M_OWN); i++)
      drive_cycle(4'b0100, 4'b0000, IDLE, B_SINGLE, 1'b1);
    drive_cycle(4'b1100, 4'b0000, NONSEQ, B_INCR4, 1'b1);
    repeat (3) drive_cycle(4'b1100, 4'b0000, SEQ, B_INCR4, 1'b1);
    drive_cycle(4'b1100, 4'b0000, IDLE, B_SINGLE, 1'b1);

    // INCR4 with wait states and a BUSY beat.
    for (int i = 0; i < 8 && !(m_owner == 3 && m_mode == M_OWN); i++)
      drive_cycle(4'b1000, 4'b0000, IDLE, B_SINGLE, 1'b1);
    drive_cycle(4'b1010, 4'b0000, NONSEQ, B_INCR4, 1'b1);
    repeat (3) drive_cycle(4'b1010, 4'b0000, SEQ, B_INCR4, 1'b0);
    drive_cycle(4'b1010, 4'b0000, BUSY, B_INCR4, 1'b1);
    repeat (3) drive_cycle(4'b1010, 4'b0000, SEQ, B_INCR4, 1'b1);
    drive_cycle(4'b1010, 4'b0000, IDLE, B_SINGLE, 1'b1);

    // Locked sequence by master 1 while everyone else requests.
    for (int i = 0; i < 8 && !(m_owner == 1 && m_mode == M_OWN); i++)
      drive_cycle(4'b0010, 4'b0000, IDLE, B_SINGLE, 1'b1);
    repeat (6) drive_cycle(4'b1111, 4'b0010, NONSEQ, B_SINGLE, 1'b1);
    drive_cycle(4'b1111, 4'b0000, IDLE, B_SINGLE, 1'b1);
    repeat (2) drive_cycle(4'b1111, 4'b0000, IDLE, B_SINGLE, 1'b1);

    // Reset in the middle of an INCR8.
    drive_cycle(4'b0101, 4'b0000, NONSEQ, B_INCR8, 1'b1);
    drive_cycle(4'b0101, 4'b0000, NONSEQ, B_INCR8, 1'b1);
    drive_cycle(4'b0101, 4'b0000, SEQ, B_INCR8, 1'b1);
    reset_mid("reset_mid_incr8");
    reset_cycle();
    repeat (3) drive_cycle(4'b0000, 4'b0000, IDLE, B_SINGLE, 1'b1);

    // Masters 0 and 3 competing with singles.
    repeat (6) drive_cycle(4'b1001, 4'b0000, NONSEQ, B_SINGLE, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        reset_mid("reset_mid_rand");
      end else begin
        rq = 4'($urandom_range(0, 15));
        lk = ($urandom_range(0, 5) == 0) ? (rq & 4'($urandom_range(0, 15))) : 4'b0000;
        drive_cycle(rq, lk, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                    ($urandom_range(0, 3) != 0));
      end
    end

    drive_cycle(4'b0000, 4'b0000, IDLE, B_SINGLE, 1'b1);
    repeat (3) @(negedge hclk);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: %0d expected responses left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ahb_arbiter.md
Name: ahb_arbiter

Overview:
- Multi-master AHB bus arbiter that shares the single AHB slave path (memory slave plus decoder) between NUM_MASTERS requesters.
- Samples bus requests and lock requests, then issues one-hot grants and drives hmaster for the address/data multiplexers.
- Respects fixed-length bursts, locked transfers and hready so the slave always sees one coherent owner per transfer.
- Parks on DEFAULT_MASTER when no master is requesting.

Parameters:
- NUM_MASTERS, 4: number of requesting masters (2..8).
- DEFAULT_MASTER, 0: master index parked on when there are no requests.
- MW, 2: width of hmaster; must satisfy 2**MW >= NUM_MASTERS.

Ports:
- hclk  in  1  bus clock.
- hresetn  in  1  reset. One clock; reset is asynchronous and active-high.
- hbusreq  in  NUM_MASTERS  per-master bus request.
- hlock  in  NUM_MASTERS  per-master lock request, qualified by hbusreq.
- htrans  in  2  transfer type of the current owner, after the bus mux.
- hburst  in  3  burst type of the current owner.
- hready  in  1  bus-level ready (slave hreadyout after the mux).
- hgrant  out  NUM_MASTERS  one-hot grant.
- hmaster  out  MW  index of the master owning the address phase.
- hmastlock  out  1  current address phase is locked.
- arb_busy  out  1  a burst or lock currently blocks re-arbitration.

Behaviour:
- Reset values:
  - hgrant = one-hot DEFAULT_MASTER.
  - hmaster = DEFAULT_MASTER.
  - hmastlock = 0, arb_busy = 0.
  - beat counter = 0, round-robin pointer = DEFAULT_MASTER.
  - state = PARK.
- Reset may assert mid-burst. All outputs return to their reset values immediately, with no wait for a clock edge.
- Burst length decode (hburst):
  - SINGLE = 1 beat.
  - INCR4 and WRAP4 = 4 beats.
  - INCR8 and WRAP8 = 8 beats.
  - INCR16 and WRAP16 = 16 beats.
  - INCR = undefined length; arbitration is allowed on any beat.
- A beat is counted on a clock edge where hready = 1 and htrans is NONSEQ (2'b10) or SEQ (2'b11).
  - NONSEQ loads the counter with length-1.
  - SEQ decrements the counter.
  - The counter saturates at 0.
- Arbitration point is any edge with hready = 1 while in PARK, OWN or BURST with the counter at 1 (the last beat is being issued). hgrant updates on that edge.
- hmaster updates to the granted index on the next edge with hready = 1. This is the address-phase handover, so hmaster lags hgrant by at least one hready cycle.
- The grant never changes while hready = 0. All outputs hold.
- Round-robin selection:
  - Search starts at pointer+1 and proceeds upward modulo NUM_MASTERS.
  - The first asserted hbusreq wins.
  - The pointer is updated to the winner.
  - If the current owner still requests and no other master does, the owner keeps the grant.
- State machine:
  - PARK: no hbusreq asserted; grant goes to DEFAULT_MASTER. Any request leads to OWN at the arbitration point.
  - OWN: owner holds the bus for single or INCR transfers.
    - NONSEQ with a fixed-length burst -> BURST.
    - hlock[owner] & hbusreq[owner] -> LOCK.
    - No requests -> PARK.
  - BURST: arbitration is blocked until the counter reaches 1. Then re-arbitrate -> OWN, LOCK or PARK.
  - LOCK: the owner keeps the grant regardless of other requests. Exit when hlock[owner] = 0 and the owner issues IDLE with hready = 1; re-arbitrate then.
- hmastlock is the registered hlock[owner], updated on the same edge as hmaster. It therefore marks exactly the locked address phases.
- arb_busy = 1 in BURST and LOCK states, otherwise 0.
- Simultaneous events:
  - Lock takes precedence over a burst end.
  - A request from the owner and from others at a non-locked arbitration point is resolved by round-robin (no starvation).
- An htrans of BUSY (2'b01) during a burst does not count as a beat, and the grant is held.

Optional Feature:
- Macro ARB_FIXED_PRIORITY_EN.
- When defined: round-robin is replaced by fixed priority. The lowest asserted index wins, the pointer is unused, and the owner is pre-empted at any arbitration point by a lower index.
- When undefined: round-robin as described above.
- Burst and lock protection apply in both modes.

Test Plan:
- Reset with hbusreq = 0 -> hgrant = 4'b0001, hmaster = 0, hmastlock = 0; hold for 5 cycles with no change.
- hbusreq = 4'b0110, singles, hready = 1 -> grants rotate 1, 2, 1, 2 on successive arbitration points; hmaster follows one hready-cycle later.
- Master 2 issues INCR4 (NONSEQ + 3 SEQ) while master 3 requests -> hgrant stays 4'b0100 until the 4th beat is issued, then becomes 4'b1000; arb_busy = 1 for beats 1-3.
- Insert hready = 0 for 3 cycles mid-burst and BUSY on beat 2 -> no grant or hmaster change, beat count still 4 transfers.
- Master 1 with hlock = 1 for 6 transfers while masters 0, 2 and 3 request -> hgrant = 4'b0010 throughout and hmastlock = 1 on those address phases; after hlock drops and IDLE is issued, grant moves to master 2.
- Assert hresetn during beat 2 of an INCR8 -> outputs return immediately to reset values and state = PARK; with ARB_FIXED_PRIORITY_EN, hbusreq = 4'b1001 always grants master 0.
